// File: rtl/dmem_master_pkg.sv
// Shared definitions for the data-memory load/store initiator.
package dmem_master_pkg;

    localparam int unsigned DMEM_ADDR_W  = 32;
    localparam int unsigned DMEM_DATA_W  = 32;
    localparam int unsigned DMEM_LANES   = 4;
    localparam int unsigned DMEM_TIMEOUT = 15;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Access cannot be issued: half on odd byte, word off a word boundary, or reserved size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = |offset;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: store lane enables/replication and load alignment/extension.
module dmem_lane
    import dmem_master_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic [1:0]            size,
    input  logic [1:0]            offset,
    input  logic                  sext,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W-1:0]     rword,
    output logic [DMEM_LANES-1:0] sel,
    output logic [DATA_W-1:0]     wdata_lane,
    output logic [DATA_W-1:0]     rdata_ext
);

    logic [DATA_W-1:0] shifted;

    // Little-endian lane selection, store replication and load extension.
    always_comb begin
        shifted    = rword >> {offset, 3'b000};
        sel        = '0;
        wdata_lane = wdata;
        rdata_ext  = shifted;
        case (size)
            SIZE_B: begin
                sel        = DMEM_LANES'(1) << offset;
                wdata_lane = {(DATA_W/8){wdata[7:0]}};
                rdata_ext  = {{(DATA_W-8){sext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                sel        = DMEM_LANES'(3) << offset;
                wdata_lane = {(DATA_W/16){wdata[15:0]}};
                rdata_ext  = {{(DATA_W-16){sext & shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                sel = '1;
            end
            default: begin
                sel = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_master.sv
// MEM-stage load/store initiator driving the data RAM port; stalls the pipeline while busy.
module dmem_master
    import dmem_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = DMEM_ADDR_W,
    parameter int unsigned DATA_W  = DMEM_DATA_W,
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  sext_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  done_o,
    output logic                  stall_o,
    output logic                  misalign_o,
    output logic                  timeout_o,
    output logic                  mem_ce_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DMEM_LANES-1:0] mem_sel_o,
    output logic [DATA_W-1:0]     mem_data_o,
    input  logic [DATA_W-1:0]     mem_data_i,
    input  logic                  mem_ready_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [1:0]            size_q, size_nx;
    logic [1:0]            off_q, off_nx;
    logic                  sext_q, sext_nx;

    logic [DATA_W-1:0]     rdata_nx;
    logic                  done_nx, misalign_nx, timeout_nx;
    logic                  ce_nx, we_nx;
    logic [ADDR_W-1:0]     addr_nx;
    logic [DMEM_LANES-1:0] sel_nx;
    logic [DATA_W-1:0]     mdata_nx;

    logic [1:0]            lane_size, lane_off;
    logic [DMEM_LANES-1:0] lane_sel;
    logic [DATA_W-1:0]     lane_wdata, lane_rdata;

    // The single lane unit serves the incoming request in IDLE and the latched one in ACCESS.
    assign lane_size = (state == ST_ACCESS) ? size_q : size_i;
    assign lane_off  = (state == ST_ACCESS) ? off_q  : addr_i[1:0];

    dmem_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .size       (lane_size),
        .offset     (lane_off),
        .sext       (sext_q),
        .wdata      (wdata_i),
        .rword      (mem_data_i),
        .sel        (lane_sel),
        .wdata_lane (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

    // Next-state, next registered outputs and combinational stall.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        size_nx     = size_q;
        off_nx      = off_q;
        sext_nx     = sext_q;
        rdata_nx    = rdata_o;
        done_nx     = 1'b0;
        misalign_nx = 1'b0;
        timeout_nx  = 1'b0;
        ce_nx       = mem_ce_o;
        we_nx       = mem_we_o;
        addr_nx     = mem_addr_o;
        sel_nx      = mem_sel_o;
        mdata_nx    = mem_data_o;
        stall_o     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_i) begin
                    if (is_misaligned(size_i, addr_i[1:0])) begin
                        misalign_nx = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        ce_nx    = CHIP_ENABLE;
                        we_nx    = we_i ? WRITE_ENABLE : WRITE_DISABLE;
                        addr_nx  = {addr_i[ADDR_W-1:2], 2'b00};
                        sel_nx   = lane_sel;
                        mdata_nx = we_i ? lane_wdata : '0;
                        size_nx  = size_i;
                        off_nx   = addr_i[1:0];
                        sext_nx  = sext_i;
                        cnt_nx   = '0;
                        state_nx = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                stall_o = 1'b1;
                if (mem_we_o) begin
                    ce_nx    = CHIP_DISABLE;
                    we_nx    = WRITE_DISABLE;
                    done_nx  = 1'b1;
                    rdata_nx = '0;
                    state_nx = ST_DONE;
                end else if (mem_ready_i) begin
                    ce_nx    = CHIP_DISABLE;
                    done_nx  = 1'b1;
                    rdata_nx = lane_rdata;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt_nx == CNT_W'(TIMEOUT)) begin
                        ce_nx      = CHIP_DISABLE;
                        timeout_nx = 1'b1;
                        rdata_nx   = '0;
                        cnt_nx     = '0;
                        state_nx   = ST_IDLE;
                    end
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            size_q     <= SIZE_B;
            off_q      <= '0;
            sext_q     <= 1'b0;
            rdata_o    <= '0;
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            timeout_o  <= 1'b0;
            mem_ce_o   <= CHIP_DISABLE;
            mem_we_o   <= WRITE_DISABLE;
            mem_addr_o <= '0;
            mem_sel_o  <= '0;
            mem_data_o <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            size_q     <= size_nx;
            off_q      <= off_nx;
            sext_q     <= sext_nx;
            rdata_o    <= rdata_nx;
            done_o     <= done_nx;
            misalign_o <= misalign_nx;
            timeout_o  <= timeout_nx;
            mem_ce_o   <= ce_nx;
            mem_we_o   <= we_nx;
            mem_addr_o <= addr_nx;
            mem_sel_o  <= sel_nx;
            mem_data_o <= mdata_nx;
        end
    end

endmodule

// File: tb/tb_dmem_master.sv
// Scoreboard bench for dmem_master with a small RAM model and configurable ready delay.
module tb_dmem_master;
    import dmem_master_pkg::*;

    localparam logic [1:0] K_DONE = 2'd0;
    localparam logic [1:0] K_MIS  = 2'd1;
    localparam logic [1:0] K_TO   = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] rdata;
        string       name;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        string       name;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, sext_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o;
    logic        done_o, stall_o, misalign_o, timeout_o;
    logic        mem_ce_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o, mem_data_i;
    logic        mem_ready_i;

    int total = 0;
    int bad   = 0;
    int ready_wait = 0;
    int wait_cnt = 0;
    logic ce_prev = 1'b0;
    logic [31:0] ram [0:15];

    resp_t resp_q[$];
    bus_t  bus_q[$];

    dmem_master dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .sext_i      (sext_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .timeout_o   (timeout_o),
        .mem_ce_o    (mem_ce_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_sel_o   (mem_sel_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ready_i (mem_ready_i)
    );

    always #5 clk = ~clk;

    // RAM model: byte-lane writes, combinational read, ready after ready_wait active cycles.
    assign mem_data_i  = ram[mem_addr_o[5:2]];
    assign mem_ready_i = mem_ce_o && !mem_we_o && (wait_cnt >= ready_wait);

    always @(posedge clk) begin
        wait_cnt <= mem_ce_o ? wait_cnt + 1 : 0;
        if (mem_ce_o && mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_sel_o[b]) ram[mem_addr_o[5:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response monitor: every completion/reject/abort pulse must match the next expectation.
    always @(negedge clk) begin : resp_mon
        resp_t e;
        logic [2:0] want;
        if (!rst && (done_o || misalign_o || timeout_o)) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", {61'd0, done_o, misalign_o, timeout_o}, 64'd0);
            end else begin
                e = resp_q.pop_front();
                want = (e.kind == K_DONE) ? 3'b100 : (e.kind == K_MIS) ? 3'b010 : 3'b001;
                check({e.name, "_kind"}, {61'd0, done_o, misalign_o, timeout_o}, {61'd0, want});
                if (e.kind != K_MIS) check({e.name, "_rdata"}, {32'd0, rdata_o}, {32'd0, e.rdata});
                if (e.kind == K_DONE) check({e.name, "_done_stall"}, {63'd0, stall_o}, 64'd0);
            end
        end
    end

    // Bus monitor: each new RAM access must match the next expected request.
    always @(negedge clk) begin : bus_mon
        bus_t e;
        if (mem_ce_o && !ce_prev) begin
            if (bus_q.size() == 0) begin
                check("unexpected_access", {32'd0, mem_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = bus_q.pop_front();
                check({e.name, "_bus"}, {27'd0, mem_we_o, mem_addr_o, mem_sel_o},
                      {27'd0, e.we, e.addr, e.sel});
                if (e.we) check({e.name, "_wdata"}, {32'd0, mem_data_o}, {32'd0, e.data});
            end
        end
        if (mem_we_o) check("we_without_ce", {63'd0, mem_ce_o}, 64'd1);
        ce_prev = mem_ce_o;
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_bus, input logic [3:0] exp_sel, input logic [31:0] exp_data,
                         input logic [1:0] exp_kind, input logic [31:0] exp_rdata,
                         input int exp_stall, input string name);
        int n;
        if (exp_bus) bus_q.push_back('{we, {addr[31:2], 2'b00}, exp_sel, exp_data, name});
        resp_q.push_back('{exp_kind, exp_rdata, name});
        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = size; sext_i = sext; addr_i = addr; wdata_i = wdata;
        #1;
        n = stall_o ? 1 : 0;
        @(negedge clk);
        req_i = 1'b0;
        if (!exp_bus) check({name, "_no_ce"}, {63'd0, mem_ce_o}, 64'd0);
        while (stall_o && n < 64) begin
            n++;
            @(negedge clk);
        end
        check({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        repeat (2) @(negedge clk);
        check({name, "_resp_seen"}, 64'(resp_q.size()), 64'd0);
        check({name, "_bus_seen"}, 64'(bus_q.size()), 64'd0);
        resp_q.delete();
        bus_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = SIZE_W; sext_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk);
        check("reset_flags", {52'd0, done_o, misalign_o, timeout_o, mem_ce_o, mem_we_o, stall_o, mem_sel_o, 2'd0}, 64'd0);
        check("reset_addr_rdata", {mem_addr_o, rdata_o}, 64'd0);
        check("reset_mdata", {32'd0, mem_data_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // stores and loads, all lane positions
        issue(1, SIZE_W, 0, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, K_DONE, 32'h0,        2, "sw_10");
        issue(0, SIZE_W, 0, 32'h10, 32'h0,        1, 4'hF, 32'h0,        K_DONE, 32'hDEADBEEF, 2, "lw_10");
        issue(1, SIZE_W, 0, 32'h10, 32'h11223344, 1, 4'hF, 32'h11223344, K_DONE, 32'h0,        2, "sw_pre1");
        issue(1, SIZE_B, 0, 32'h13, 32'h000000AA, 1, 4'h8, 32'hAAAAAAAA, K_DONE, 32'h0,        2, "sb_13");
        issue(0, SIZE_W, 0, 32'h10, 32'h0,        1, 4'hF, 32'h0,        K_DONE, 32'hAA223344, 2, "lw_after_sb");
        issue(1, SIZE_W, 0, 32'h10, 32'h00800000, 1, 4'hF, 32'h00800000, K_DONE, 32'h0,        2, "sw_pre2");
        issue(0, SIZE_B, 1, 32'h12, 32'h0,        1, 4'h4, 32'h0,        K_DONE, 32'hFFFFFF80, 2, "lb_12");
        issue(0, SIZE_B, 0, 32'h12, 32'h0,        1, 4'h4, 32'h0,        K_DONE, 32'h00000080, 2, "lbu_12");
        issue(1, SIZE_W, 0, 32'h10, 32'hBEEF0000, 1, 4'hF, 32'hBEEF0000, K_DONE, 32'h0,        2, "sw_pre3");
        issue(0, SIZE_H, 0, 32'h12, 32'h0,        1, 4'hC, 32'h0,        K_DONE, 32'h0000BEEF, 2, "lhu_12");
        issue(0, SIZE_H, 1, 32'h12, 32'h0,        1, 4'hC, 32'h0,        K_DONE, 32'hFFFFBEEF, 2, "lh_12");
        issue(1, SIZE_W, 0, 32'h14, 32'h0,        1, 4'hF, 32'h0,        K_DONE, 32'h0,        2, "sw_14");
        issue(1, SIZE_H, 0, 32'h16, 32'h1234CAFE, 1, 4'hC, 32'hCAFECAFE, K_DONE, 32'h0,        2, "sh_16");
        issue(0, SIZE_W, 0, 32'h14, 32'h0,        1, 4'hF, 32'h0,        K_DONE, 32'hCAFE0000, 2, "lw_14");
        issue(0, SIZE_B, 1, 32'h17, 32'h0,        1, 4'h8, 32'h0,        K_DONE, 32'hFFFFFFCA, 2, "lb_17");

        // rejected requests: no RAM access, no stall
        issue(0, SIZE_H, 1, 32'h11, 32'h0,        0, 4'h0, 32'h0,        K_MIS,  32'h0,        0, "lh_11_mis");
        issue(0, SIZE_W, 0, 32'h12, 32'h0,        0, 4'h0, 32'h0,        K_MIS,  32'h0,        0, "lw_12_mis");
        issue(1, 2'b11,  0, 32'h10, 32'h0,        0, 4'h0, 32'h0,        K_MIS,  32'h0,        0, "size11_mis");
        issue(1, SIZE_H, 0, 32'h13, 32'h5555AAAA, 0, 4'h0, 32'h0,        K_MIS,  32'h0,        0, "sh_13_mis");

        // ready never arrives: abort after the timeout window
        ready_wait = 1000;
        issue(0, SIZE_W, 0, 32'h10, 32'h0,        1, 4'hF, 32'h0,        K_TO,   32'h0,        16, "lw_timeout");

        // ready after three wait cycles; misaligned store above must not have written
        ready_wait = 3;
        issue(0, SIZE_W, 0, 32'h10, 32'h0,        1, 4'hF, 32'h0,        K_DONE, 32'hBEEF0000, 5, "lw_wait3");

        // reset while a load is waiting in ACCESS
        ready_wait = 1000;
        bus_q.push_back('{1'b0, 32'h10, 4'hF, 32'h0, "lw_rst"});
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; size_i = SIZE_W; sext_i = 1'b0; addr_i = 32'h10;
        @(negedge clk);
        req_i = 1'b0;
        check("rst_pre_ce", {63'd0, mem_ce_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_flags", {52'd0, done_o, misalign_o, timeout_o, mem_ce_o, mem_we_o, stall_o, mem_sel_o, 2'd0}, 64'd0);
        check("rst_mid_addr_rdata", {mem_addr_o, rdata_o}, 64'd0);
        repeat (4) @(negedge clk);
        check("rst_bus_seen", 64'(bus_q.size()), 64'd0);
        bus_q.delete();
        ready_wait = 0;
        issue(0, SIZE_W, 0, 32'h14, 32'h0,        1, 4'hF, 32'h0,        K_DONE, 32'hCAFE0000, 2, "lw_after_rst");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
